// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display driver.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern.
  always_comb begin
    seg_o = SEG_TABLE[hex_i];
  end

endmodule

// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed hex display driver with tear-free frame update,
// anti-ghost blanking and optional leading-zero suppression.
module seven_seg_display_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] displayOut,
  input  logic        dispWrite,
  input  logic        blankLeading,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frameStart
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  digit_idx_t       digitIdx_q, digitIdx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [15:0]      active_q, active_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frameStart_q, frameStart_d;

  logic             slot_last;
  logic             frame_wrap;
  logic [3:0]       nibble;
  logic [6:0]       seg_raw;
  logic [3:0]       upper_zero;
  logic             digit_blank;

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (nibble),
    .seg_o (seg_raw)
  );

  // Scan counter, capture/transfer registers and next pin values.
  always_comb begin
    slot_last  = (divCnt_q == DIV_W'(REFRESH_DIV - 1));
    frame_wrap = slot_last && (digitIdx_q == digit_idx_t'(NUM_DIGITS - 1));

    divCnt_d     = slot_last ? '0 : divCnt_q + 1'b1;
    digitIdx_d   = slot_last ? digitIdx_q + 1'b1 : digitIdx_q;
    frameStart_d = frame_wrap;
    // The old shadow is transferred; a write on the wrap edge waits a frame.
    active_d     = frame_wrap ? shadow_q : active_q;
    shadow_d     = dispWrite ? displayOut : shadow_q;

    nibble = active_q[{digitIdx_q, 2'b00} +: 4];

    // upper_zero[k]: nibbles k..3 of the displayed word are all zero.
    upper_zero = {(active_q[15:12] == 4'h0),
                  (active_q[15:8]  == 8'h00),
                  (active_q[15:4]  == 12'h000),
                  1'b1};
    digit_blank = blankLeading && (digitIdx_q != '0) && upper_zero[digitIdx_q];

    if (digit_blank || (divCnt_q < DIV_W'(BLANK_CYCLES))) begin
      an_d = AN_OFF;
    end else begin
      an_d = ~(4'b0001 << digitIdx_q);
    end
    seg_d = digit_blank ? SEG_OFF : seg_raw;
  end

  // State and registered pin outputs; reset blanks the display immediately.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      divCnt_q     <= '0;
      digitIdx_q   <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frameStart_q <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      digitIdx_q   <= digitIdx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frameStart = frameStart_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver against a cycle-position model.
module tb_seven_seg_display_driver;

  localparam int unsigned DIV   = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 4 * DIV;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [15:0] displayOut = '0;
  logic        dispWrite = 1'b0;
  logic        blankLeading = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frameStart;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: edges since reset release, captured word, displayed word.
  int unsigned c = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_active = '0;

  logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seven_seg_display_driver #(
    .REFRESH_DIV  (DIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .displayOut   (displayOut),
    .dispWrite    (dispWrite),
    .blankLeading (blankLeading),
    .seg          (seg),
    .an           (an),
    .frameStart   (frameStart)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check_eq({tag, "_an"}, 16'(an), 16'hf);
    check_eq({tag, "_seg"}, 16'(seg), 16'h7f);
    check_eq({tag, "_fs"}, 16'(frameStart), 16'h0);
  endtask

  // One clock cycle: drive inputs at a negedge, predict, check at the next negedge.
  task automatic step(input logic wr, input logic [15:0] val, input logic bl);
    int unsigned div, dig, nib;
    logic        blanked;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fs;
    dispWrite    = wr;
    displayOut   = val;
    blankLeading = bl;
    div = c % DIV;
    dig = (c / DIV) % 4;
    nib = int'((m_active >> (4 * dig)) & 16'hf);
    blanked = bl && (dig != 0) && ((m_active >> (4 * dig)) == 16'h0);
    e_seg = blanked ? 7'h7f : SEG_REF[nib];
    e_an  = 4'hf;
    if (!blanked && div >= BLANK) e_an[dig] = 1'b0;
    e_fs  = ((c + 1) % FRAME) == 0;
    if (e_fs) m_active = m_shadow;
    if (wr) m_shadow = val;
    c++;
    @(negedge CLK);
    check_eq("an", 16'(an), 16'(e_an));
    check_eq("seg", 16'(seg), 16'(e_seg));
    check_eq("frameStart", 16'(frameStart), 16'(e_fs));
    check_eq("an_onehot", 16'($countones(~an) <= 1), 16'h1);
  endtask

  task automatic idle(input int unsigned n, input logic bl);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 16'h0, bl);
  endtask

  task automatic release_reset();
    dispWrite = 1'b0;
    RESET_N   = 1'b1;
    c         = 0;
    m_shadow  = '0;
    m_active  = '0;
  endtask

  initial begin
    logic [15:0] v;
    #1 RESET_N = 1'b0;
    #1 check_reset_pins("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check_reset_pins("reset_hold");
    end
    release_reset();

    // Idle scan of zeros.
    idle(2 * FRAME, 1'b0);

    // Mid-frame write must not tear the current frame.
    idle(12, 1'b0);
    step(1'b1, 16'h13B0, 1'b0);
    idle(3 * FRAME, 1'b0);

    // Write coinciding with the wrap edge is deferred one frame.
    while (((c + 1) % FRAME) != 0) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    idle(3 * FRAME, 1'b0);

    // Leading-zero suppression.
    step(1'b1, 16'h0008, 1'b1);
    idle(3 * FRAME, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    idle(2 * FRAME + 5, 1'b1);
    step(1'b1, 16'h0A05, 1'b1);
    idle(2 * FRAME + 3, 1'b1);

    // Asynchronous reset mid-slot.
    #2 RESET_N = 1'b0;
    #1 check_reset_pins("reset_mid");
    @(negedge CLK);
    check_reset_pins("reset_mid_hold");
    release_reset();
    idle(FRAME + 4, 1'b1);

    // Continuous tracking: write tied high, value changes every 5 cycles.
    v = 16'($urandom);
    for (int unsigned i = 0; i < 6 * FRAME; i++) begin
      if (i % 5 == 0) v = 16'($urandom);
      step(1'b1, v, 1'b0);
    end

    // Random mix, upper nibbles often zero to exercise suppression.
    for (int unsigned i = 0; i < 40 * FRAME; i++) begin
      v = 16'($urandom);
      case ($urandom_range(0, 3))
        0: v = v & 16'h000f;
        1: v = v & 16'h00ff;
        2: v = v & 16'h0fff;
        default: ;
      endcase
      step(($urandom_range(0, 7) == 0), v, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
